// File: rtl/compress_rr_sched.sv
// Round-robin scheduler sharing one INT8 saturating re-quantiser between N_LANE accumulator lanes.
// Optional macro SAT_STATS_EN adds o_sat_cnt (per-batch count of clipped results delivered).
module compress_rr_sched #(
  parameter int N_LANE    = 4,
  parameter int SUM_WIDTH = 20,
  parameter int ID_W      = 2,
  parameter int BATCH     = 16
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic [N_LANE-1:0]           i_req,
  input  logic [N_LANE*SUM_WIDTH-1:0] i_sum_in,
  output logic [N_LANE-1:0]           o_gnt,
  output logic                        o_out_valid,
  input  logic                        i_out_ready,
  output logic [7:0]                  o_out_data,
  output logic [ID_W-1:0]             o_out_id,
  output logic                        o_out_sat,
`ifdef SAT_STATS_EN
  output logic [15:0]                 o_sat_cnt,
`endif
  output logic                        o_batch_done
);

  localparam int CNT_W = $clog2(BATCH + 1);
  localparam int HI_W  = SUM_WIDTH - 8;
  localparam logic signed [HI_W-1:0] HI_MAX = HI_W'(127);
  localparam logic signed [HI_W-1:0] HI_MIN = HI_W'(-128);

  logic                 r_valid;
  logic [7:0]           r_data;
  logic [ID_W-1:0]      r_id;
  logic                 r_sat;
  logic [ID_W-1:0]      r_ptr;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_batch_done;

  logic                 w_accept;
  logic                 w_hs;
  logic                 w_found;
  logic [ID_W-1:0]      w_idx;
  logic [N_LANE-1:0]    w_gnt;
  logic [SUM_WIDTH-1:0] w_sum;
  logic signed [HI_W-1:0] w_hi;
  logic [7:0]           w_data;
  logic                 w_sat;
  logic                 w_unused;

  // Single output register: a new result may enter whenever the old one leaves this cycle.
  assign w_accept = ~r_valid | i_out_ready;
  assign w_hs     = r_valid & i_out_ready;

  always_comb begin
    w_found = 1'b0;
    w_idx   = '0;
    if (w_accept) begin
      for (int k = 1; k <= N_LANE; k++) begin
        if (!w_found && i_req[(int'(r_ptr) + k) % N_LANE]) begin
          w_found = 1'b1;
          w_idx   = ID_W'((int'(r_ptr) + k) % N_LANE);
        end
      end
    end
    w_gnt = w_found ? (N_LANE'(1) << w_idx) : '0;
  end

  assign w_sum    = i_sum_in[int'(w_idx)*SUM_WIDTH +: SUM_WIDTH];
  assign w_hi     = w_sum[SUM_WIDTH-1:8];
  assign w_unused = ^w_sum[7:0];

  // Low byte is dropped outright, so negative values floor rather than round.
  always_comb begin
    w_data = w_sum[15:8];
    w_sat  = 1'b0;
    if (w_hi > HI_MAX) begin
      w_data = 8'h7F;
      w_sat  = 1'b1;
    end else if (w_hi < HI_MIN) begin
      w_data = 8'h80;
      w_sat  = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_id    <= '0;
      r_sat   <= 1'b0;
      r_ptr   <= ID_W'(N_LANE - 1);
    end else if (w_found) begin
      r_valid <= 1'b1;
      r_data  <= w_data;
      r_id    <= w_idx;
      r_sat   <= w_sat;
      r_ptr   <= w_idx;
    end else if (w_hs) begin
      r_valid <= 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt        <= '0;
      r_batch_done <= 1'b0;
    end else begin
      r_batch_done <= 1'b0;
      if (w_hs) begin
        if (r_cnt == CNT_W'(BATCH - 1)) begin
          r_cnt        <= '0;
          r_batch_done <= 1'b1;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

`ifdef SAT_STATS_EN
  logic [15:0] r_sat_cnt;

  // A clipped result delivered on the batch_done cycle belongs to the new batch.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sat_cnt <= '0;
    end else if (r_batch_done) begin
      r_sat_cnt <= (w_hs && r_sat) ? 16'd1 : 16'd0;
    end else if (w_hs && r_sat && (r_sat_cnt != 16'hFFFF)) begin
      r_sat_cnt <= r_sat_cnt + 16'd1;
    end
  end

  assign o_sat_cnt = r_sat_cnt;
`endif

  assign o_gnt        = w_gnt;
  assign o_out_valid  = r_valid;
  assign o_out_data   = r_data;
  assign o_out_id     = r_id;
  assign o_out_sat    = r_sat;
  assign o_batch_done = r_batch_done;

endmodule
